// File: rtl/mem_preload_seq.sv
// Preload/run/drain sequencer: streams words into an accelerator RAM, releases
// the accelerator from reset, waits for completion and streams the results out.
module mem_preload_seq #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int LOAD_WORDS   = 12,
    parameter int RESULT_BASE  = 12,
    parameter int RESULT_WORDS = 3,
    parameter int RUN_TIMEOUT  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  dbg_wr_en,
    output logic [ADDR_WIDTH-1:0] dbg_wr_addr,
    output logic [DATA_WIDTH-1:0] dbg_wr_data,
    output logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dut_rst,
    input  logic                  dut_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [2:0]            fsm_state
);
    // Handshakes: a word moves on any rising edge where valid and ready are
    // both 1; valid-side payload is held stable until that edge.
    localparam int LCW = $clog2(LOAD_WORDS + 1);
    localparam int RCW = $clog2(RUN_TIMEOUT + 1);
    localparam int DCW = $clog2(RESULT_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_SETTLE, S_DRAIN, S_DONE
    } state_t;

    state_t         state;
    logic [LCW-1:0] load_cnt;
    logic [RCW-1:0] run_cnt;
    logic           settle_cnt;
    logic [DCW-1:0] rd_cnt;

    assign fsm_state = state;
    // Result payload comes straight from the combinational RAM read port.
    assign out_data  = out_valid ? dbg_data : '0;
    assign out_addr  = out_valid ? dbg_addr : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            dbg_wr_en   <= 1'b0;
            dbg_wr_addr <= '0;
            dbg_wr_data <= '0;
            dbg_addr    <= '0;
            dut_rst     <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            load_cnt    <= '0;
            run_cnt     <= '0;
            settle_cnt  <= 1'b0;
            rd_cnt      <= '0;
        end else begin
            dbg_wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LOAD;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        load_cnt   <= '0;
                        run_cnt    <= '0;
                        settle_cnt <= 1'b0;
                        rd_cnt     <= '0;
                        dbg_addr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        dbg_wr_en   <= 1'b1;
                        dbg_wr_addr <= ADDR_WIDTH'(load_cnt);
                        dbg_wr_data <= in_data;
                        load_cnt    <= load_cnt + LCW'(1);
                        if (load_cnt == LCW'(LOAD_WORDS - 1)) begin
                            state    <= S_RUN;
                            in_ready <= 1'b0;
                            dut_rst  <= 1'b0;
                            run_cnt  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // Completion on the last counted cycle still wins over timeout.
                    if (dut_valid) begin
                        state      <= S_SETTLE;
                        settle_cnt <= 1'b0;
                    end else if (run_cnt == RCW'(RUN_TIMEOUT - 1)) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        dut_rst <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + RCW'(1);
                    end
                end
                S_SETTLE: begin
                    // Two idle cycles let the RAM's delayed write port land.
                    if (settle_cnt) begin
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                        rd_cnt    <= '0;
                        dbg_addr  <= ADDR_WIDTH'(RESULT_BASE);
                    end else begin
                        settle_cnt <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt == DCW'(RESULT_WORDS - 1)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            dut_rst   <= 1'b1;
                        end else begin
                            rd_cnt   <= rd_cnt + DCW'(1);
                            dbg_addr <= dbg_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_preload_seq.sv
// Bench for mem_preload_seq: a RAM plus a 3x3 mat-vec accelerator model around
// the sequencer, with a reference computed from the words the bench loads.
module tb_mem_preload_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        dbg_wr_en;
    logic [4:0]  dbg_wr_addr;
    logic [31:0] dbg_wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dut_rst;
    logic        dut_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [2:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_preload_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dbg_wr_en(dbg_wr_en), .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dut_rst(dut_rst), .dut_valid(dut_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done), .timeout(timeout), .fsm_state(fsm_state)
    );

    // RAM with combinational read and an accelerator whose result writes land
    // three edges after it raises dut_valid.
    logic [31:0] ram [32];
    bit          acc_en;
    int          acc_delay;
    int          acc_cnt;
    assign dbg_data = ram[dbg_addr];

    function automatic logic [31:0] acc_row(int r);
        logic [31:0] s = '0;
        for (int c = 0; c < 3; c++) s += ram[3*r+c] * ram[9+c];
        return s;
    endfunction

    always @(posedge clk) begin
        if (dbg_wr_en) ram[dbg_wr_addr] <= dbg_wr_data;
        if (dut_rst) begin
            acc_cnt   <= 0;
            dut_valid <= 1'b0;
            for (int i = 0; i < 3; i++) ram[12+i] <= 32'hBAD0_0000 + 32'(i);
        end else if (acc_en) begin
            if (acc_cnt == acc_delay) dut_valid <= 1'b1;
            if (acc_cnt == acc_delay + 3)
                for (int r = 0; r < 3; r++) ram[12+r] <= acc_row(r);
            acc_cnt <= acc_cnt + 1;
        end
    end

    // Scoreboard state.
    logic [31:0] words [12];
    logic [36:0] exp_q [$];
    bit          wr_pend;
    logic [4:0]  wr_exp_addr;
    logic [31:0] wr_exp_data;
    int          load_idx;
    bit          acc_now;
    bit          prev_stall;
    logic [4:0]  prev_addr;
    logic [31:0] prev_data;
    int          ov_seen;
    int          rst_low;
    int          sent;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mat-vec reference: rows 0..2 of a 3x3 matrix in words[0..8] times words[9..11].
    task automatic build_expected();
        exp_q.delete();
        for (int r = 0; r < 3; r++) begin
            logic [31:0] s = '0;
            for (int c = 0; c < 3; c++) s += words[3*r+c] * words[9+c];
            exp_q.push_back({5'(12 + r), s});
        end
    endtask

    // One clock: sample and check at the falling edge, return 1 after the rising edge.
    task automatic step();
        @(negedge clk);
        if (wr_pend) begin
            chk(64'(dbg_wr_en), 64'd1, "wr_pulse");
            chk(64'(dbg_wr_addr), 64'(wr_exp_addr), "wr_addr");
            chk(64'(dbg_wr_data), 64'(wr_exp_data), "wr_data");
        end else begin
            chk(64'(dbg_wr_en), 64'd0, "wr_idle");
        end
        acc_now = (rst === 1'b1) && in_valid && (in_ready === 1'b1);
        wr_pend = acc_now;
        if (acc_now) begin
            wr_exp_addr = 5'(load_idx);
            wr_exp_data = in_data;
            load_idx++;
        end
        if (prev_stall) begin
            chk(64'(out_valid), 64'd1, "stall_valid");
            chk(64'(out_addr), 64'(prev_addr), "stall_addr");
            chk(64'(out_data), 64'(prev_data), "stall_data");
        end
        if (out_valid === 1'b1) ov_seen++;
        if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_out observed=%0h:%0h expected=none", out_addr, out_data);
            end else begin
                chk(64'({out_addr, out_data}), 64'(exp_q.pop_front()), "out_word");
            end
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_addr  = out_addr;
        prev_data  = out_data;
        if (dut_rst === 1'b0) rst_low++;
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start();
        load_idx   = 0;
        ov_seen    = 0;
        rst_low    = 0;
        sent       = 0;
        prev_stall = 1'b0;
        start      = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        step();
        start = 1'b0;
    endtask

    // gap_mode: 0 always valid, 1 every other cycle, 2 random.
    // out_mode: 0 always ready, 1 five-cycle stall after first result, 2 random.
    task automatic run_seq(input int gap_mode, input int out_mode, input bit exp_to);
        bit fin = 1'b0;
        if (exp_to) exp_q.delete();
        else build_expected();
        issue_start();
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc == 0) begin
                chk(64'(done), 64'd0, "restart_done");
                chk(64'(timeout), 64'd0, "restart_timeout");
                chk(64'(busy), 64'd1, "load_busy");
                chk(64'(in_ready), 64'd1, "load_ready");
            end
            if (sent < 12) begin
                in_data  = words[sent];
                in_valid = (gap_mode == 0) ? 1'b1 :
                           (gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            end else begin
                in_data  = $urandom;
                in_valid = 1'($urandom_range(0, 1));
            end
            if (out_mode == 1) out_ready = !(ov_seen >= 1 && ov_seen <= 5);
            else if (out_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            step();
            if (acc_now) sent++;
            if (done === 1'b1) fin = 1'b1;
        end
        in_valid = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $error("FAIL done_wait observed=not_done expected=done_within_600");
        end
        chk(64'(sent), 64'd12, "words_accepted");
        chk(64'(timeout), 64'(exp_to), "timeout_flag");
        chk(64'(busy), 64'd0, "done_busy");
        chk(64'(dut_rst), 64'd1, "done_dut_rst");
        chk(64'(out_valid), 64'd0, "done_out_valid");
        chk(64'(in_ready), 64'd0, "done_in_ready");
        chk(64'(exp_q.size()), 64'd0, "results_left");
        if (exp_to) begin
            chk(64'(ov_seen), 64'd0, "to_no_out");
            chk(64'(rst_low), 64'd100, "to_run_cycles");
        end
        step();
        chk(64'(done), 64'd1, "done_held");
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        acc_en    = 1'b1;
        acc_delay = 5;
        wr_pend   = 1'b0;
        load_idx  = 0;
        for (int i = 0; i < 32; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(64'(in_ready), 64'd0, "rst_in_ready");
        chk(64'(out_valid), 64'd0, "rst_out_valid");
        chk(64'(dbg_wr_en), 64'd0, "rst_wr_en");
        chk(64'(dut_rst), 64'd1, "rst_dut_rst");
        chk(64'({busy, done, timeout}), 64'd0, "rst_flags");
        chk(64'({dbg_addr, dbg_wr_addr, out_addr}), 64'd0, "rst_addrs");
        chk(64'({dbg_wr_data, out_data}), 64'd0, "rst_data");
        chk(64'(fsm_state), 64'd0, "rst_state");
        rst = 1'b1;
        step();

        // Nominal run: expected stream (12,71),(13,83),(14,114).
        words = '{32'd6, 32'd1, 32'd2, 32'd3, 32'd7, 32'd5, 32'd5, 32'd2, 32'd9, 32'd9, 32'd3, 32'd7};
        run_seq(0, 0, 1'b0);

        // Backpressure on both streams with random data.
        for (int i = 0; i < 12; i++) words[i] = $urandom;
        acc_delay = $urandom_range(0, 20);
        run_seq(1, 1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) words[i] = $urandom_range(0, 1000);
            acc_delay = $urandom_range(0, 30);
            run_seq(2, 2, 1'b0);
        end

        // Accelerator never completes.
        acc_en = 1'b0;
        run_seq(0, 0, 1'b1);

        // Completion on the final counted RUN cycle beats the timeout.
        acc_en    = 1'b1;
        acc_delay = 98;
        for (int i = 0; i < 12; i++) words[i] = $urandom;
        run_seq(0, 0, 1'b0);

        // Reset after five words, with start held during reset.
        acc_delay = 4;
        issue_start();
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && sent < 5; cyc++) begin
            in_data = words[sent];
            step();
            if (acc_now) sent++;
            if (sent == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk(64'(sent), 64'd5, "partial_sent");
        step();
        step();
        rst   = 1'b0;
        start = 1'b1;
        step();
        chk(64'(in_ready), 64'd0, "mid_rst_in_ready");
        chk(64'(dut_rst), 64'd1, "mid_rst_dut_rst");
        chk(64'({busy, done, timeout}), 64'd0, "mid_rst_flags");
        chk(64'(fsm_state), 64'd0, "mid_rst_state");
        step();
        rst   = 1'b1;
        start = 1'b0;
        step();
        chk(64'(busy), 64'd0, "start_ignored_in_rst");
        chk(64'(in_ready), 64'd0, "start_ignored_ready");

        // Fresh load from address 0, then a restart from DONE with identical output.
        words = '{32'd6, 32'd1, 32'd2, 32'd3, 32'd7, 32'd5, 32'd5, 32'd2, 32'd9, 32'd9, 32'd3, 32'd7};
        run_seq(0, 0, 1'b0);
        run_seq(0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
